// File: rtl/alu_seq_ctrl_pkg.sv
// Shared ALU control definitions: field widths, ALUOp classes, op codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_ctrl_pkg;

  localparam int FUNC_LEN  = 10;
  localparam int ALUOP_LEN = 2;
  localparam int CTRL_LEN  = 4;
  localparam int CNT_LEN   = 8;

  typedef enum logic [ALUOP_LEN-1:0] {
    ALUOP_LSW = 2'd0,
    ALUOP_BR  = 2'd1,
    ALUOP_R   = 2'd2,
    ALUOP_I   = 2'd3
  } aluop_e;

  typedef enum logic [CTRL_LEN-1:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_MULH = 4'd11,
    OP_DIV  = 4'd12, OP_DIVU = 4'd13, OP_REM  = 4'd14, OP_REMU = 4'd15
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Plain integer op selected by funct3 (funct7 = 0000000 flavour).
  function automatic alu_op_e base_op(input logic [2:0] f3);
    alu_op_e op;
    case (f3)
      3'b000:  op = OP_ADD;
      3'b001:  op = OP_SLL;
      3'b010:  op = OP_SLT;
      3'b011:  op = OP_SLTU;
      3'b100:  op = OP_XOR;
      3'b101:  op = OP_SRL;
      3'b110:  op = OP_OR;
      default: op = OP_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_decode.sv
// Combinational decode of {funct7, funct3} and ALUOp into an ALU op code plus class flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
module alu_decode
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned M_EN = 1
) (
  input  logic [FUNC_LEN-1:0]  funct_i,
  input  logic [ALUOP_LEN-1:0] ALUOp_i,
  output logic [CTRL_LEN-1:0]  code_o,
  output logic                 illegal_o,
  output logic                 is_mul_o,
  output logic                 is_div_o
);

  logic [6:0] f7;
  logic [2:0] f3;

  assign f7 = funct_i[FUNC_LEN-1:3];
  assign f3 = funct_i[2:0];

  // Illegal encodings leave code_o at ADD and never raise a class flag.
  always_comb begin
    code_o    = OP_ADD;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    is_div_o  = 1'b0;
    case (ALUOp_i)
      ALUOP_LSW: code_o = OP_ADD;
      ALUOP_BR:  code_o = OP_SUB;
      ALUOP_R: begin
        if (f7 == F7_BASE) begin
          code_o = base_op(f3);
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'b000:  code_o = OP_SUB;
            3'b101:  code_o = OP_SRA;
            default: illegal_o = 1'b1;
          endcase
        end else if ((f7 == F7_MULDIV) && (M_EN != 0)) begin
          case (f3)
            3'b000: begin code_o = OP_MUL;  is_mul_o = 1'b1; end
            3'b001: begin code_o = OP_MULH; is_mul_o = 1'b1; end
            3'b100: begin code_o = OP_DIV;  is_div_o = 1'b1; end
            3'b101: begin code_o = OP_DIVU; is_div_o = 1'b1; end
            3'b110: begin code_o = OP_REM;  is_div_o = 1'b1; end
            3'b111: begin code_o = OP_REMU; is_div_o = 1'b1; end
            default: illegal_o = 1'b1;
          endcase
        end else begin
          illegal_o = 1'b1;
        end
      end
      default: begin
        // I-type: funct7 is immediate bits except for the shift encodings.
        case (f3)
          3'b001: begin
            if (f7 == F7_BASE) code_o = OP_SLL;
            else               illegal_o = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_BASE)     code_o = OP_SRL;
            else if (f7 == F7_ALT) code_o = OP_SRA;
            else                   illegal_o = 1'b1;
          end
          default: code_o = base_op(f3);
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU control sequencer: registers decoded op code, holds off new requests during MUL/DIV.
// Latency: code valid 1 cycle after accept; multi-cycle ops busy for MUL_LAT/DIV_LAT cycles.
// Backpressure: ready_o low while BUSY; flush_i aborts an in-flight op or drops a request.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned M_EN    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [FUNC_LEN-1:0]  funct_i,
  input  logic [ALUOP_LEN-1:0] ALUOp_i,
  input  logic                 flush_i,
  output logic [CTRL_LEN-1:0]  ALUCtrl_o,
  output logic                 ctrl_valid_o,
  output logic                 stall_o,
  output logic                 mc_done_o,
  output logic                 illegal_o
);

  localparam logic [CNT_LEN-1:0] MUL_LOAD = CNT_LEN'(MUL_LAT - 1);
  localparam logic [CNT_LEN-1:0] DIV_LOAD = CNT_LEN'(DIV_LAT - 1);

  state_e               state_q, state_d;
  logic [CNT_LEN-1:0]   cnt_q, cnt_d;
  logic [CTRL_LEN-1:0]  ctrl_q, ctrl_d;
  logic                 cv_q, cv_d;
  logic                 ill_q, ill_d;

  logic [CTRL_LEN-1:0]  dec_code;
  logic                 dec_ill;
  logic                 dec_mul;
  logic                 dec_div;
  logic                 accept;

  alu_decode #(
    .M_EN (M_EN)
  ) u_decode (
    .funct_i   (funct_i),
    .ALUOp_i   (ALUOp_i),
    .code_o    (dec_code),
    .illegal_o (dec_ill),
    .is_mul_o  (dec_mul),
    .is_div_o  (dec_div)
  );

  // Flush has priority over a simultaneous request.
  assign accept = valid_i && (state_q == S_IDLE) && !flush_i;

  // Next-state, counter and output decode; the counter holds the BUSY cycles still to go after this one.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    cv_d      = 1'b0;
    ill_d     = 1'b0;
    ready_o   = 1'b0;
    stall_o   = 1'b0;
    mc_done_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (accept) begin
          ctrl_d = dec_code;
          cv_d   = 1'b1;
          ill_d  = dec_ill;
          if (dec_mul) begin
            state_d = S_BUSY;
            cnt_d   = MUL_LOAD;
          end else if (dec_div) begin
            state_d = S_BUSY;
            cnt_d   = DIV_LOAD;
          end
        end
      end
      default: begin
        stall_o = 1'b1;
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          mc_done_o = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= OP_ADD;
      cv_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      cv_q    <= cv_d;
      ill_q   <= ill_d;
    end
  end

  assign ALUCtrl_o    = ctrl_q;
  assign ctrl_valid_o = cv_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: decode table, multi-cycle corner sequences, random vs model.
// Two instances share stimulus: u_a with M extension, u_b with M_EN=0.
// Outputs are sampled 1 time unit after the falling edge, inputs driven on the falling edge.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic       flush_i;
  logic [9:0] funct_i;
  logic [1:0] ALUOp_i;

  logic       a_ready, a_cv, a_stall, a_mcd, a_ill;
  logic [3:0] a_ctrl;
  logic       b_ready, b_cv, b_stall, b_mcd, b_ill;
  logic [3:0] b_ctrl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .M_EN(1)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(a_ready),
    .funct_i(funct_i), .ALUOp_i(ALUOp_i), .flush_i(flush_i),
    .ALUCtrl_o(a_ctrl), .ctrl_valid_o(a_cv), .stall_o(a_stall),
    .mc_done_o(a_mcd), .illegal_o(a_ill)
  );

  alu_seq_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .M_EN(0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(b_ready),
    .funct_i(funct_i), .ALUOp_i(ALUOp_i), .flush_i(flush_i),
    .ALUCtrl_o(b_ctrl), .ctrl_valid_o(b_cv), .stall_o(b_stall),
    .mc_done_o(b_mcd), .illegal_o(b_ill)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference decode straight from the op tables: returns code, illegal flag and busy length.
  function automatic void ref_decode(input logic [1:0] op, input logic [6:0] f7,
                                     input logic [2:0] f3, input bit men,
                                     output int code, output bit ill, output int lat);
    int base [8];
    int mext [8];
    base = '{0, 5, 8, 9, 4, 6, 3, 2};
    mext = '{10, 11, -1, -1, 12, 13, 14, 15};
    code = 0; ill = 0; lat = 0;
    case (op)
      2'd0: code = 0;
      2'd1: code = 1;
      2'd2: begin
        if (f7 == 7'h00) code = base[f3];
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) code = (f3 == 3'd0) ? 1 : 7;
        else if (f7 == 7'h01 && men && mext[f3] >= 0) begin
          code = mext[f3];
          lat  = (code < 12) ? MUL_LAT : DIV_LAT;
        end else ill = 1;
      end
      default: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (f7 == 7'h00) code = base[f3];
          else if (f3 == 3'd5 && f7 == 7'h20) code = 7;
          else ill = 1;
        end else code = base[f3];
      end
    endcase
    if (ill) code = 0;
  endfunction

  // Cycle model: remaining BUSY cycles, last code, one-cycle pulses.
  int m_left [2];
  int m_ctrl [2];
  bit m_cv   [2];
  bit m_ill  [2];

  function automatic logic [8:0] exp_vec(input int k);
    logic [3:0] c;
    c = m_ctrl[k][3:0];
    return {m_left[k] == 0, m_left[k] > 0, (m_left[k] == 1) && !flush_i, m_cv[k], m_ill[k], c};
  endfunction

  task automatic model_step(input int k, input bit men);
    int code, lat;
    bit ill, acc;
    acc = valid_i && (m_left[k] == 0) && !flush_i;
    if (m_left[k] > 0) m_left[k] = flush_i ? 0 : m_left[k] - 1;
    m_cv[k] = 0; m_ill[k] = 0;
    if (acc) begin
      ref_decode(ALUOp_i, funct_i[9:3], funct_i[2:0], men, code, ill, lat);
      m_ctrl[k] = code; m_cv[k] = 1; m_ill[k] = ill; m_left[k] = lat;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
    valid_i = 1'b1; ALUOp_i = op; funct_i = {f7, f3};
  endtask

  task automatic do_reset();
    rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [3:0] code;
    logic       ill;
    logic       mc;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int seen;
    int st;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct_i = '0; ALUOp_i = '0;
    #1 rst_i = 1'b0;
    @(negedge clk_i); #1;
    chk("reset_a", {a_ready, a_stall, a_mcd, a_cv, a_ill, a_ctrl}, 9'b1_0000_0000);
    chk("reset_b", {b_ready, b_stall, b_mcd, b_cv, b_ill, b_ctrl}, 9'b1_0000_0000);
    @(negedge clk_i) rst_i = 1'b1;

    // Decode table on the M-enabled instance: {op, funct7, funct3, code, illegal, multi-cycle}.
    tbl[0]  = '{2'd0, 7'h7F, 3'd7, 4'd0,  1'b0, 1'b0};
    tbl[1]  = '{2'd1, 7'h55, 3'd3, 4'd1,  1'b0, 1'b0};
    tbl[2]  = '{2'd2, 7'h00, 3'd7, 4'd2,  1'b0, 1'b0};
    tbl[3]  = '{2'd2, 7'h20, 3'd0, 4'd1,  1'b0, 1'b0};
    tbl[4]  = '{2'd2, 7'h20, 3'd5, 4'd7,  1'b0, 1'b0};
    tbl[5]  = '{2'd2, 7'h20, 3'd7, 4'd0,  1'b1, 1'b0};
    tbl[6]  = '{2'd2, 7'h00, 3'd1, 4'd5,  1'b0, 1'b0};
    tbl[7]  = '{2'd2, 7'h01, 3'd0, 4'd10, 1'b0, 1'b1};
    tbl[8]  = '{2'd2, 7'h01, 3'd3, 4'd0,  1'b1, 1'b0};
    tbl[9]  = '{2'd2, 7'h01, 3'd7, 4'd15, 1'b0, 1'b1};
    tbl[10] = '{2'd2, 7'h02, 3'd0, 4'd0,  1'b1, 1'b0};
    tbl[11] = '{2'd3, 7'h7F, 3'd0, 4'd0,  1'b0, 1'b0};
    tbl[12] = '{2'd3, 7'h20, 3'd5, 4'd7,  1'b0, 1'b0};
    tbl[13] = '{2'd3, 7'h00, 3'd5, 4'd6,  1'b0, 1'b0};
    tbl[14] = '{2'd3, 7'h20, 3'd1, 4'd0,  1'b1, 1'b0};
    tbl[15] = '{2'd3, 7'h7F, 3'd6, 4'd3,  1'b0, 1'b0};
    tbl[16] = '{2'd3, 7'h01, 3'd5, 4'd0,  1'b1, 1'b0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_i) drive(tbl[i].op, tbl[i].f7, tbl[i].f3);
      @(negedge clk_i) valid_i = 1'b0;
      #1;
      chk($sformatf("tbl%0d_out", i), {a_cv, a_ill, a_ctrl}, {1'b1, tbl[i].ill, tbl[i].code});
      chk($sformatf("tbl%0d_stall", i), a_stall, tbl[i].mc);
      flush_i = tbl[i].mc;
      @(negedge clk_i) flush_i = 1'b0;
      #1 chk($sformatf("tbl%0d_ready", i), a_ready, 1'b1);
    end

    // Back-to-back single-cycle ops: AND then SUB.
    do_reset();
    @(negedge clk_i) drive(2'd2, 7'h00, 3'd7);
    @(negedge clk_i) drive(2'd2, 7'h20, 3'd0);
    #1 chk("b2b_first", {a_cv, a_stall, a_ctrl}, {1'b1, 1'b0, 4'd2});
    @(negedge clk_i) valid_i = 1'b0;
    #1 chk("b2b_second", {a_cv, a_stall, a_ctrl}, {1'b1, 1'b0, 4'd1});
    @(negedge clk_i) #1 chk("b2b_after", {a_cv, a_stall, a_ctrl}, {1'b0, 1'b0, 4'd1});

    // MUL with MUL_LAT=3: stall T+1..T+3, done at T+3, ready at T+4.
    @(negedge clk_i) drive(2'd2, 7'h01, 3'd0);
    @(negedge clk_i) valid_i = 1'b0;
    #1 chk("mul_code", {a_cv, a_ctrl}, {1'b1, 4'd10});
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) #1;
      chk($sformatf("mul_t%0d", k), {a_stall, a_mcd, a_ready},
          {k <= 3, k == 3, k == 4});
      @(negedge clk_i);
    end

    // DIV flushed at T+5: IDLE at T+6, no done pulse, code stays 12.
    drive(2'd2, 7'h01, 3'd4);
    @(negedge clk_i) valid_i = 1'b0;
    seen = 0; st = 0;
    for (int k = 1; k <= 5; k++) begin
      #1 seen += a_mcd; st += a_stall;
      if (k == 5) flush_i = 1'b1;
      @(negedge clk_i);
    end
    flush_i = 1'b0;
    chk("div_stall_cycles", st, 5);
    #1 chk("div_flush_idle", {a_ready, a_stall, a_ctrl}, {1'b1, 1'b0, 4'd12});
    repeat (20) begin @(negedge clk_i); #1 seen += a_mcd; end
    chk("div_flush_no_done", seen, 0);

    // Illegal ops: SUB-family funct3 111 on both, and MUL on the M_EN=0 instance.
    @(negedge clk_i) drive(2'd2, 7'h20, 3'd7);
    @(negedge clk_i) drive(2'd2, 7'h01, 3'd0);
    #1 chk("ill_alt_a", {a_cv, a_ill, a_stall, a_ctrl}, {1'b1, 1'b1, 1'b0, 4'd0});
    @(negedge clk_i) valid_i = 1'b0;
    #1 chk("ill_mul_noM", {b_cv, b_ill, b_stall, b_ctrl}, {1'b1, 1'b1, 1'b0, 4'd0});
    @(negedge clk_i) #1 chk("ill_pulse_end", {b_ill, b_stall, b_ready}, 3'b001);
    flush_i = 1'b1;
    @(negedge clk_i) flush_i = 1'b0;

    // Flush in IDLE drops a simultaneous request.
    @(negedge clk_i) begin drive(2'd1, 7'h00, 3'd0); flush_i = 1'b1; end
    @(negedge clk_i) begin valid_i = 1'b0; flush_i = 1'b0; end
    #1 chk("idle_flush_drop", {a_cv, a_ready, a_ctrl}, {1'b0, 1'b1, 4'd10});

    // Asynchronous reset mid-BUSY.
    @(negedge clk_i) drive(2'd2, 7'h01, 3'd6);
    @(negedge clk_i) valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #3 rst_i = 1'b0;
    #1 chk("arst_mid_busy", {a_stall, a_ready, a_mcd, a_ctrl}, {1'b0, 1'b1, 1'b0, 4'd0});
    @(negedge clk_i) rst_i = 1'b1;
    seen = 0; st = 0;
    repeat (25) begin @(negedge clk_i); #1 seen += a_mcd; st += a_stall; end
    chk("arst_no_done", {seen[15:0], st[15:0]}, 32'd0);

    // Random traffic against the cycle model on both instances.
    do_reset();
    for (int k = 0; k < 2; k++) begin m_left[k] = 0; m_ctrl[k] = 0; m_cv[k] = 0; m_ill[k] = 0; end
    for (int c = 0; c < 800; c++) begin
      logic [6:0] f7;
      @(negedge clk_i);
      valid_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 4))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        3:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      funct_i = {f7, 3'($urandom)};
      ALUOp_i = ($urandom_range(0, 1) != 0) ? 2'd2 : 2'($urandom);
      #1;
      chk("rand_a", {a_ready, a_stall, a_mcd, a_cv, a_ill, a_ctrl}, exp_vec(0));
      chk("rand_b", {b_ready, b_stall, b_mcd, b_cv, b_ill, b_ctrl}, exp_vec(1));
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
